gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Parametrised gshare branch predictor for the instruction fetch stage, and the successor to the fixed 512-entry bimodal table. It has these parts:
- A global history register (GHR) that is updated speculatively at fetch and repaired by the ROB on a mispredict.
- A table of saturating counters whose width and depth are set by parameters.
- A hardware table-initialisation sweep after reset.

Fetch gets a combinational next-PC and taken flag, plus the history snapshot that travels with the instruction. The ROB trains the counters at commit.

## Interface
Parameters:
- `IDX_BITS`, 9, log2 of counter-table depth.
- `HIST_BITS`, 8, GHR length; must be 1..`IDX_BITS`.
- `CTR_BITS`, 2, counter width; must be ≥ 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; when low, all state is frozen.
- `fetch_valid` in 1: `ins_cur` is a real fetched instruction this cycle.
- `pc_cur` in 32: PC of `ins_cur`.
- `ins_cur` in 32: fetched instruction word.
- `pc_pred` out 32: predicted next PC.
- `pred_taken` out 1: predicted taken; goes to the dispatcher.
- `pred_hist` out `HIST_BITS`: GHR value before this instruction's shift; travels with the instruction to the ROB.
- `init_busy` out 1: high during the table-init sweep.
- `upd_valid` in 1: ROB commits a conditional branch.
- `upd_pc` in 32: PC of the committed branch.
- `upd_taken` in 1: actual outcome of the committed branch.
- `upd_hist` in `HIST_BITS`: the `pred_hist` value that was carried with the branch.
- `upd_mispredict` in 1: the branch was mispredicted; repair the GHR.

## Operation
Decode of `ins_cur[6:0]`:
- `1101111` is JAL.
- `1100111` is JALR.
- `1100011` is a conditional branch.
- Anything else is not a control-flow instruction.

Immediates:
- JAL uses the J-type immediate.
- Branches use the B-type immediate.
- Both are sign-extended to 32 bits.

Table index:
- `idx = pc_cur[IDX_BITS+1:2] XOR {0, ghr}`, with the GHR zero-extended into the low bits.
- The update index uses the same formula with `upd_pc` and `upd_hist`.

Prediction (combinational):
- JAL: taken.
- JALR: not taken; `pc_pred = pc_cur+4`.
- Branch: taken when the counter MSB is 1.
- Other: not taken.
- `pc_pred = pred_taken ? pc_cur+imm : pc_cur+4`, computed mod 2^32.

Counters:
- Saturating, range 0..2^CTR_BITS−1.
- On update, taken increments and not-taken decrements; both clamp at the limits.
- The initial value is weakly not-taken, 2^(CTR_BITS−1)−1 (1 for the 2-bit case).

GHR:
- Speculative shift: when `fetch_valid` and the instruction is a branch, `ghr <= {ghr[HIST_BITS-2:0], pred_taken}`.
- Repair: when `upd_valid && upd_mispredict`, `ghr <= {upd_hist[HIST_BITS-2:0], upd_taken}`. Repair has priority over the speculative shift in the same cycle.
- JAL and JALR never shift the GHR.

State machine:
- INIT: `init_ptr` walks from 0 to 2^IDX_BITS−1, writing the initial value to one entry per cycle. `init_busy` is 1.
  - Branch predictions are not-taken.
  - JAL is still predicted taken.
  - Updates are dropped.
  - The GHR is held at 0.
- RUN: after the last entry is written, the FSM moves to RUN on the next edge.
- Assertion of `rst` from any state returns the FSM to INIT with `init_ptr` at 0.

Simultaneous events:
- A fetch read and an update write to the same index in one cycle: the read returns the old value, and the write lands at the edge.
- `upd_valid` with `upd_mispredict=0` trains the counter and leaves the GHR untouched.

## Timing
Reset values:
- FSM in INIT, `init_ptr`=0, `ghr`=0, `init_busy`=1.
- `pred_taken`, `pc_pred` and `pred_hist` follow the combinational inputs: not-taken, `pc_cur+4`, 0.

Latencies:
- Prediction is zero-latency (combinational from `pc_cur`, `ins_cur` and the table).
- A counter update is visible to a prediction one cycle after `upd_valid`.
- A GHR shift or repair is visible in the next cycle's index.

Init duration:
- INIT lasts exactly 2^IDX_BITS cycles with `rdy`=1.
- The first RUN cycle is cycle 2^IDX_BITS after `rst` deasserts.
- `rdy` low stalls the sweep.

Stall behaviour: with `rdy`=0 there are no writes, no GHR changes and no FSM advance. Outputs remain combinational.

## Configuration
`PRED_GSHARE_EN`:
- Defined: the GHR is XORed into both indices as above.
- Undefined: the block is a bimodal predictor.
  - `idx = pc[IDX_BITS+1:2]`.
  - The GHR register is removed and `pred_hist` is tied to 0.
  - `upd_hist` and `upd_mispredict` are ignored.
  - The INIT sweep and counter behaviour are unchanged.

## Test plan
Defaults apply (`IDX_BITS`=9, `HIST_BITS`=8, `CTR_BITS`=2).

1. **Init sweep.** Release `rst` and present branch `0xFE000EE3` at `pc_cur=0x100`.
   - `init_busy`=1 for 512 cycles.
   - `pred_taken`=0 and `pc_pred`=0x104 throughout.
   - `init_busy`=0 at cycle 512.
2. **Jumps.**
   - JAL with +8 at 0x200: `pc_pred`=0x208, `pred_taken`=1, GHR unchanged.
   - JALR: `pc_pred`=0x204, `pred_taken`=0.
3. **Counter saturation** (with `PRED_GSHARE_EN` undefined).
   - Two taken updates for PC 0x100: predicts taken next cycle.
   - Five more taken updates: counter stays 3.
   - Two not-taken updates: predicts not-taken.
4. **Speculative shift.** Three fetched branches predicted 0,0,0, starting with GHR=0: `pred_hist` reads 0x00, 0x00, 0x00 and the GHR ends at 0.
   - Then force counter MSB=1 at the index: the next branch shows `pred_hist`=0 and the GHR becomes 0x01.
5. **Mispredict repair priority.** GHR=0x0F, with a fetched branch and an update in the same cycle (`upd_mispredict`=1, `upd_hist`=0x3C, `upd_taken`=1).
   - GHR becomes 0x79.
   - The speculative shift is discarded.
6. **Mid-sweep reset.**
   - Assert `rst` at `init_ptr`=200: the pointer restarts at 0 and the full 512-cycle sweep repeats.
   - `rdy`=0 for 10 cycles mid-sweep: the sweep extends by exactly 10 cycles.

Source files
------------

// File: rtl/gshare_predictor_if.sv
// Fetch-side prediction signals and ROB-side training signals of gshare_predictor.
interface gshare_predictor_if #(
  parameter int HIST_BITS = 8
);
  logic                 fetch_valid;
  logic [31:0]          pc_cur;
  logic [31:0]          ins_cur;
  logic [31:0]          pc_pred;
  logic                 pred_taken;
  logic [HIST_BITS-1:0] pred_hist;
  logic                 upd_valid;
  logic [31:0]          upd_pc;
  logic                 upd_taken;
  logic [HIST_BITS-1:0] upd_hist;
  logic                 upd_mispredict;

  modport master (
    output fetch_valid, pc_cur, ins_cur,
    output upd_valid, upd_pc, upd_taken, upd_hist, upd_mispredict,
    input  pc_pred, pred_taken, pred_hist
  );

  modport slave (
    input  fetch_valid, pc_cur, ins_cur,
    input  upd_valid, upd_pc, upd_taken, upd_hist, upd_mispredict,
    output pc_pred, pred_taken, pred_hist
  );
endinterface

// File: rtl/gshare_predictor.sv
// gshare branch predictor with speculative GHR, saturating counters and a post-reset init sweep.
// Define PRED_GSHARE_EN to XOR the GHR into the index; undefined builds a plain bimodal predictor.
module gshare_predictor #(
  parameter int IDX_BITS  = 9,
  parameter int HIST_BITS = 8,
  parameter int CTR_BITS  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              init_busy,
  gshare_predictor_if.slave bus
);
  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               state_reg, state_next;
  logic [IDX_BITS-1:0]  init_ptr_reg, init_ptr_next;
  logic [CTR_BITS-1:0]  ctr_mem [DEPTH];

  logic                 tbl_we;
  logic [IDX_BITS-1:0]  tbl_waddr;
  logic [CTR_BITS-1:0]  tbl_wdata;

  logic [6:0]           opcode;
  logic                 is_jal, is_jalr, is_br;
  logic [31:0]          imm_j, imm_b;
  logic [IDX_BITS-1:0]  fetch_idx, upd_idx;
  logic [CTR_BITS-1:0]  fetch_ctr, upd_ctr, upd_ctr_sat;
  logic                 pred_taken_w;
  logic [HIST_BITS-1:0] hist_cur, upd_hist_eff;

  // ---------------- decode ----------------
  assign opcode  = bus.ins_cur[6:0];
  assign is_jal  = (opcode == 7'b1101111);
  assign is_jalr = (opcode == 7'b1100111);
  assign is_br   = (opcode == 7'b1100011);

  assign imm_j = {{11{bus.ins_cur[31]}}, bus.ins_cur[31], bus.ins_cur[19:12],
                  bus.ins_cur[20], bus.ins_cur[30:21], 1'b0};
  assign imm_b = {{19{bus.ins_cur[31]}}, bus.ins_cur[31], bus.ins_cur[7],
                  bus.ins_cur[30:25], bus.ins_cur[11:8], 1'b0};

  // ---------------- history selection ----------------
`ifdef PRED_GSHARE_EN
  logic [HIST_BITS-1:0] ghr_reg, ghr_next;

  assign hist_cur     = ghr_reg;
  assign upd_hist_eff = bus.upd_hist;

  // Repair from the ROB outranks the speculative shift of a younger fetch.
  always_comb begin
    ghr_next = ghr_reg;
    if (state_reg == ST_INIT) begin
      ghr_next = '0;
    end else if (bus.upd_valid && bus.upd_mispredict) begin
      ghr_next = HIST_BITS'({bus.upd_hist, bus.upd_taken});
    end else if (bus.fetch_valid && is_br) begin
      ghr_next = HIST_BITS'({ghr_reg, pred_taken_w});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_reg <= '0;
    end else if (rdy) begin
      ghr_reg <= ghr_next;
    end
  end
`else
  logic unused_hist;

  assign hist_cur     = '0;
  assign upd_hist_eff = '0;
  assign unused_hist  = ^{bus.upd_hist, bus.upd_mispredict, bus.fetch_valid, is_jalr};
`endif

  logic unused_upd_pc;
  assign unused_upd_pc = ^{bus.upd_pc[31:IDX_BITS+2], bus.upd_pc[1:0]};

  // History occupies the low index bits; higher bits come straight from the PC.
  for (genvar gi = 0; gi < IDX_BITS; gi++) begin : g_idx
    if (gi < HIST_BITS) begin : g_xor
      assign fetch_idx[gi] = bus.pc_cur[gi+2] ^ hist_cur[gi];
      assign upd_idx[gi]   = bus.upd_pc[gi+2] ^ upd_hist_eff[gi];
    end else begin : g_pc
      assign fetch_idx[gi] = bus.pc_cur[gi+2];
      assign upd_idx[gi]   = bus.upd_pc[gi+2];
    end
  end

  // ---------------- prediction ----------------
  assign fetch_ctr    = ctr_mem[fetch_idx];
  assign pred_taken_w = is_jal | (is_br & (state_reg == ST_RUN) & fetch_ctr[CTR_BITS-1]);

  assign bus.pred_taken = pred_taken_w;
  assign bus.pc_pred    = pred_taken_w ? (bus.pc_cur + (is_jal ? imm_j : imm_b))
                                       : (bus.pc_cur + 32'd4);
  assign bus.pred_hist  = hist_cur;
  assign init_busy      = (state_reg == ST_INIT);

  // ---------------- training ----------------
  assign upd_ctr = ctr_mem[upd_idx];

  always_comb begin
    upd_ctr_sat = upd_ctr;
    if (bus.upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_sat = upd_ctr + CTR_ONE;
    end else begin
      if (upd_ctr != '0) upd_ctr_sat = upd_ctr - CTR_ONE;
    end
  end

  // ---------------- FSM and table write port ----------------
  always_comb begin
    state_next    = state_reg;
    init_ptr_next = init_ptr_reg;
    tbl_we        = 1'b0;
    tbl_waddr     = init_ptr_reg;
    tbl_wdata     = CTR_INIT;
    case (state_reg)
      ST_INIT: begin
        if (rdy && !rst) begin
          tbl_we        = 1'b1;
          init_ptr_next = init_ptr_reg + 1'b1;
          if (init_ptr_reg == IDX_BITS'(DEPTH - 1)) state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rdy && !rst && bus.upd_valid) begin
          tbl_we    = 1'b1;
          tbl_waddr = upd_idx;
          tbl_wdata = upd_ctr_sat;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_INIT;
      init_ptr_reg <= '0;
    end else if (rdy) begin
      state_reg    <= state_next;
      init_ptr_reg <= init_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) ctr_mem[tbl_waddr] <= tbl_wdata;
  end
endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_gshare_predictor;
  localparam int IDX_BITS  = 9;
  localparam int HIST_BITS = 8;
  localparam int CTR_BITS  = 2;
  localparam int DEPTH     = 1 << IDX_BITS;
  localparam int CMAX      = (1 << CTR_BITS) - 1;
  localparam int CINIT     = (1 << (CTR_BITS - 1)) - 1;
`ifdef PRED_GSHARE_EN
  localparam bit GSHARE = 1'b1;
`else
  localparam bit GSHARE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic init_busy;

  gshare_predictor_if #(.HIST_BITS(HIST_BITS)) bus();

  gshare_predictor #(
    .IDX_BITS(IDX_BITS), .HIST_BITS(HIST_BITS), .CTR_BITS(CTR_BITS)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .init_busy(init_busy), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int m_ctr [DEPTH];
  int m_ghr = 0;
  bit m_busy = 1'b1;
  int m_init_cnt = 0;
  int cur_kind = 0;   // 0 other, 1 JAL, 2 JALR, 3 conditional branch
  int cur_imm = 0;

  function automatic int m_idx(input logic [31:0] pc, input int hist);
    int base;
    base = int'((pc / 4) % DEPTH);
    return GSHARE ? (base ^ hist) : base;
  endfunction

  function automatic bit exp_taken();
    if (cur_kind == 1) return 1'b1;
    if (cur_kind == 3 && !m_busy) return m_ctr[m_idx(bus.pc_cur, m_ghr)] >= (CMAX + 1) / 2;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_pc();
    return exp_taken() ? bus.pc_cur + 32'(cur_imm) : bus.pc_cur + 32'd4;
  endfunction

  task automatic model_edge();
    bit t;
    int i;
    if (rst) begin
      m_busy = 1'b1; m_init_cnt = 0; m_ghr = 0;
    end else if (rdy) begin
      if (m_busy) begin
        m_ctr[m_init_cnt] = CINIT;
        m_init_cnt++;
        if (m_init_cnt == DEPTH) m_busy = 1'b0;
      end else begin
        t = exp_taken();
        if (bus.upd_valid) begin
          i = m_idx(bus.upd_pc, GSHARE ? int'(bus.upd_hist) : 0);
          if (bus.upd_taken) m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
          else               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
        if (GSHARE) begin
          if (bus.upd_valid && bus.upd_mispredict)
            m_ghr = (int'(bus.upd_hist) * 2 + int'(bus.upd_taken)) % (1 << HIST_BITS);
          else if (bus.fetch_valid && cur_kind == 3)
            m_ghr = (m_ghr * 2 + int'(t)) % (1 << HIST_BITS);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Encodes an instruction of the given class carrying the given immediate.
  task automatic set_ins(input int kind, input int imm);
    logic [31:0] im;
    logic [31:0] r;
    im = imm;
    r = $urandom;
    cur_kind = kind;
    cur_imm = imm;
    case (kind)
      1: bus.ins_cur = {im[20], im[10:1], im[11], im[19:12], r[11:7], 7'b1101111};
      2: bus.ins_cur = {r[31:7], 7'b1100111};
      3: bus.ins_cur = {im[12], im[10:5], r[24:15], r[14:12], im[4:1], im[11], 7'b1100011};
      default: bus.ins_cur = {r[31:7], 7'b0010011};
    endcase
  endtask

  function automatic int rand_j();
    logic [31:0] v;
    v = $urandom & 32'h001F_FFFE;
    if (v[20]) v = v | 32'hFFE0_0000;
    return int'(v);
  endfunction

  function automatic int rand_b();
    logic [31:0] v;
    v = $urandom & 32'h0000_1FFE;
    if (v[12]) v = v | 32'hFFFF_E000;
    return int'(v);
  endfunction

  task automatic idle();
    bus.fetch_valid = 1'b0; bus.pc_cur = 32'h0; set_ins(0, 0);
    bus.upd_valid = 1'b0; bus.upd_pc = 32'h0; bus.upd_taken = 1'b0;
    bus.upd_hist = '0; bus.upd_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; idle();
    bus.pc_cur = 32'h100; bus.fetch_valid = 1'b1; set_ins(3, -4);
    tick(); tick();
    @(negedge clk);
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %0b want 1", init_busy); end
    checks++; if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL reset_taken: got %0b want 0", bus.pred_taken); end
    checks++; if (bus.pc_pred !== 32'h104) begin failures++; $display("FAIL reset_pc_pred: got %h want 00000104", bus.pc_pred); end
    checks++; if (bus.pred_hist !== 8'h00) begin failures++; $display("FAIL reset_hist: got %h want 00", bus.pred_hist); end
    tick();
  endtask

  task automatic test_init_sweep();
    rst = 1'b0;
    bus.pc_cur = 32'h100; bus.ins_cur = 32'hFE00_0EE3; cur_kind = 3; cur_imm = -4;
    bus.fetch_valid = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h100; bus.upd_taken = 1'b1;
    bus.upd_mispredict = 1'b1; bus.upd_hist = 8'hFF;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL sweep_busy cycle %0d: got %0b want 1", i, init_busy); end
      checks++; if (bus.pred_taken !== 1'b0 || bus.pc_pred !== 32'h104)
        begin failures++; $display("FAIL sweep_pred cycle %0d: got %0b/%h want 0/00000104", i, bus.pred_taken, bus.pc_pred); end
      tick();
    end
    @(negedge clk);
    checks++; if (init_busy !== 1'b0) begin failures++; $display("FAIL sweep_done: got %0b want 0", init_busy); end
    checks++; if (bus.pred_hist !== 8'h00) begin failures++; $display("FAIL sweep_hist_held: got %h want 00", bus.pred_hist); end
    checks++; if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL sweep_dropped_updates: got %0b want 0", bus.pred_taken); end
    idle();
    tick();
  endtask

  task automatic test_jumps();
    logic [7:0] h0;
    h0 = 8'(m_ghr);
    idle(); bus.fetch_valid = 1'b1;
    bus.pc_cur = 32'h200; set_ins(1, 8);
    @(negedge clk);
    checks++; if (bus.pc_pred !== 32'h208 || bus.pred_taken !== 1'b1)
      begin failures++; $display("FAIL jal_pos: got %h/%0b want 00000208/1", bus.pc_pred, bus.pred_taken); end
    tick();
    bus.pc_cur = 32'h1000; set_ins(1, -16);
    @(negedge clk);
    checks++; if (bus.pc_pred !== 32'hFF0 || bus.pred_taken !== 1'b1)
      begin failures++; $display("FAIL jal_neg: got %h/%0b want 00000ff0/1", bus.pc_pred, bus.pred_taken); end
    tick();
    bus.pc_cur = 32'h200; set_ins(2, 0);
    @(negedge clk);
    checks++; if (bus.pc_pred !== 32'h204 || bus.pred_taken !== 1'b0)
      begin failures++; $display("FAIL jalr: got %h/%0b want 00000204/0", bus.pc_pred, bus.pred_taken); end
    tick();
    @(negedge clk);
    checks++; if (bus.pred_hist !== h0) begin failures++; $display("FAIL jump_ghr_unchanged: got %h want %h", bus.pred_hist, h0); end
    idle();
  endtask

  task automatic test_saturation();
    idle();
    bus.pc_cur = 32'h100; set_ins(3, 32'h40);
    bus.upd_pc = 32'h100; bus.upd_hist = 8'(m_ghr); bus.upd_valid = 1'b1; bus.upd_taken = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (bus.pred_taken !== 1'b1 || bus.pc_pred !== 32'h140)
      begin failures++; $display("FAIL sat_two_taken: got %0b/%h want 1/00000140", bus.pred_taken, bus.pc_pred); end
    for (int i = 0; i < 5; i++) tick();
    bus.upd_taken = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (bus.pred_taken !== 1'b1) begin failures++; $display("FAIL sat_clamp_high: got %0b want 1", bus.pred_taken); end
    tick();
    bus.upd_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.pred_taken !== 1'b0 || bus.pc_pred !== 32'h104)
      begin failures++; $display("FAIL sat_two_not_taken: got %0b/%h want 0/00000104", bus.pred_taken, bus.pc_pred); end
    idle();
  endtask

  task automatic test_spec_shift();
    idle();
    bus.pc_cur = 32'h180; set_ins(3, 32'h20); bus.fetch_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.pred_hist !== 8'h00 || bus.pred_taken !== 1'b0)
        begin failures++; $display("FAIL shift_nt_%0d: got hist %h taken %0b want 00/0", i, bus.pred_hist, bus.pred_taken); end
      tick();
    end
    bus.fetch_valid = 1'b0;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h180; bus.upd_hist = 8'h00; bus.upd_taken = 1'b1;
    tick();
    bus.upd_valid = 1'b0; bus.fetch_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.pred_hist !== 8'h00 || bus.pred_taken !== 1'b1)
      begin failures++; $display("FAIL shift_taken: got hist %h taken %0b want 00/1", bus.pred_hist, bus.pred_taken); end
    tick();
    bus.fetch_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.pred_hist !== (GSHARE ? 8'h01 : 8'h00))
      begin failures++; $display("FAIL shift_result: got %h want %h", bus.pred_hist, GSHARE ? 8'h01 : 8'h00); end
    idle();
  endtask

  task automatic test_repair();
    idle();
    bus.upd_valid = 1'b1; bus.upd_mispredict = 1'b1; bus.upd_hist = 8'h07;
    bus.upd_taken = 1'b1; bus.upd_pc = 32'h500;
    tick();
    @(negedge clk);
    checks++; if (bus.pred_hist !== (GSHARE ? 8'h0F : 8'h00))
      begin failures++; $display("FAIL repair_setup: got %h want %h", bus.pred_hist, GSHARE ? 8'h0F : 8'h00); end
    bus.fetch_valid = 1'b1; bus.pc_cur = 32'h240; set_ins(3, 32'h10);
    bus.upd_hist = 8'h3C; bus.upd_pc = 32'h504;
    tick();
    bus.fetch_valid = 1'b0; bus.upd_mispredict = 1'b0; bus.upd_hist = 8'hAA;
    @(negedge clk);
    checks++; if (bus.pred_hist !== (GSHARE ? 8'h79 : 8'h00))
      begin failures++; $display("FAIL repair_priority: got %h want %h", bus.pred_hist, GSHARE ? 8'h79 : 8'h00); end
    tick();
    @(negedge clk);
    checks++; if (bus.pred_hist !== (GSHARE ? 8'h79 : 8'h00))
      begin failures++; $display("FAIL train_keeps_ghr: got %h want %h", bus.pred_hist, GSHARE ? 8'h79 : 8'h00); end
    idle();
  endtask

  task automatic test_back_to_back();
    bit want [3];
    want[0] = 1'b0; want[1] = 1'b0; want[2] = 1'b1;
    idle();
    bus.pc_cur = 32'h3C0; set_ins(3, 32'h80);
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h3C0; bus.upd_hist = 8'(m_ghr); bus.upd_taken = 1'b0;
    tick(); tick();
    bus.upd_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.pred_taken !== want[i])
        begin failures++; $display("FAIL same_index_%0d: got %0b want %0b", i, bus.pred_taken, want[i]); end
      tick();
    end
    idle();
  endtask

  task automatic test_random();
    int k;
    logic [31:0] epc;
    for (int n = 0; n < 800; n++) begin
      rdy = ($urandom_range(0, 9) != 0);
      bus.pc_cur = ($urandom_range(0, 1) == 0) ? (32'h100 + 32'($urandom_range(0, 15)) * 4)
                                               : ($urandom & 32'hFFFF_FFFC);
      k = $urandom_range(0, 5);
      if (k <= 2)      set_ins(3, rand_b());
      else if (k == 3) set_ins(1, rand_j());
      else if (k == 4) set_ins(2, 0);
      else             set_ins(0, 0);
      bus.fetch_valid = $urandom_range(0, 1);
      bus.upd_valid = $urandom_range(0, 1);
      bus.upd_taken = $urandom_range(0, 1);
      bus.upd_mispredict = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        bus.upd_pc = bus.pc_cur; bus.upd_hist = 8'(m_ghr);
      end else begin
        bus.upd_pc = 32'h100 + 32'($urandom_range(0, 15)) * 4; bus.upd_hist = 8'($urandom);
      end
      @(negedge clk);
      epc = exp_pc();
      checks++; if (bus.pred_taken !== exp_taken() || bus.pc_pred !== epc || bus.pred_hist !== 8'(m_ghr))
        begin failures++;
          $display("FAIL random_%0d: got taken %0b pc %h hist %h want %0b %h %h",
                   n, bus.pred_taken, bus.pc_pred, bus.pred_hist, exp_taken(), epc, 8'(m_ghr)); end
      tick();
    end
    rdy = 1'b1;
    idle();
  endtask

  task automatic test_mid_sweep_reset();
    int cnt;
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 200; i++) tick();
    @(negedge clk);
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL midreset_busy: got %0b want 1", init_busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (!init_busy) break;
      cnt++;
      tick();
    end
    checks++; if (cnt != DEPTH) begin failures++; $display("FAIL midreset_len: got %0d cycles want %0d", cnt, DEPTH); end
    tick();
  endtask

  task automatic test_rdy_stall();
    int cnt;
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    bus.pc_cur = 32'h300; set_ins(1, 32'h20); bus.fetch_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 700; i++) begin
      rdy = !(i >= 100 && i < 110);
      @(negedge clk);
      if (!init_busy) break;
      if (i == 105) begin
        checks++; if (bus.pred_taken !== 1'b1 || bus.pc_pred !== 32'h320)
          begin failures++; $display("FAIL init_jal: got %0b/%h want 1/00000320", bus.pred_taken, bus.pc_pred); end
      end
      cnt++;
      tick();
    end
    rdy = 1'b1;
    checks++; if (cnt != DEPTH + 10) begin failures++; $display("FAIL stall_len: got %0d cycles want %0d", cnt, DEPTH + 10); end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_init_sweep();
    test_jumps();
    test_saturation();
    test_spec_shift();
    test_repair();
    test_back_to_back();
    test_random();
    test_mid_sweep_reset();
    test_rdy_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
